// File: rtl/pll1280.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : pll1280                                                     |
// | Purpose  : Synthesizable clock generator. Divides inclk0 into four     |
// |            phase-related clocks with a common time base, and provides  |
// |            a lock flag after a fixed settling count.                   |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module pll1280 #(
  parameter int DIV0        = 10,
  parameter int DIV1        = 2,
  parameter int DIV2        = 8,
  parameter int DIV3        = 8,
  parameter int PHASE0      = 0,
  parameter int PHASE1      = 0,
  parameter int PHASE2      = 0,
  parameter int PHASE3      = 2,
  parameter int LOCK_CYCLES = 64
) (
  input  logic inclk0,
  input  logic nreset,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic locked
);

  localparam int            LW          = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_TARGET = LW'(LOCK_CYCLES);

  logic [1:0]    sync;
  logic          rst_n_i;
  logic          active;
  logic [LW-1:0] lock_cnt;
  logic [LW-1:0] lock_cnt_next;
  logic          locked_next;
  logic [3:0]    clk_q;

  // Reset synchronizer: asserts asynchronously, releases after two edges.
  always_ff @(posedge inclk0 or negedge nreset) begin
    if (!nreset) sync <= 2'b00;
    else         sync <= {sync[0], 1'b1};
  end

  // sync[1] clears asynchronously with nreset, so every downstream register
  // also drops immediately, even for a pulse shorter than one inclk0 cycle.
  assign rst_n_i = sync[1];

  // Low on the edge at t=0 so the phase counters present their load value
  // there; from t=1 on they advance every edge.
  always_ff @(posedge inclk0 or negedge rst_n_i) begin
    if (!rst_n_i) active <= 1'b0;
    else          active <= 1'b1;
  end

  // Saturating lock counter next-state; locked_next lets the enables react
  // on the very edge where locked rises.
  always_comb begin
    lock_cnt_next = lock_cnt;
    if (lock_cnt != LOCK_TARGET) lock_cnt_next = lock_cnt + LW'(1);
    locked_next = locked | (lock_cnt_next == LOCK_TARGET);
  end

  // Lock counter and sticky lock flag.
  always_ff @(posedge inclk0 or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      lock_cnt <= lock_cnt_next;
      locked   <= locked_next;
    end
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_chan
      localparam int DIV   = (i == 0) ? DIV0 : (i == 1) ? DIV1 :
                             (i == 2) ? DIV2 : DIV3;
      localparam int PHASE = (i == 0) ? PHASE0 : (i == 1) ? PHASE1 :
                             (i == 2) ? PHASE2 : PHASE3;
      localparam int           W    = (DIV > 1) ? $clog2(DIV) : 1;
      localparam logic [W-1:0] LOAD = W'((DIV - PHASE) % DIV);
      localparam logic [W-1:0] LAST = W'(DIV - 1);
      localparam logic [W:0]   HIGH = (W + 1)'((DIV + 1) / 2);

      logic [W-1:0] p;
      logic [W-1:0] p_next;
      logic         en;
      logic         en_next;

      // Phase counter next value (equals (t - PHASE) mod DIV at edge t) and
      // enable that only opens at the start of a high phase.
      always_comb begin
        p_next = p;
        if (active) p_next = (p == LAST) ? '0 : p + W'(1);
        en_next = en | (locked_next && (p_next == '0));
      end

      // Registered output: high for the first HIGH counts of each period.
      always_ff @(posedge inclk0 or negedge rst_n_i) begin
        if (!rst_n_i) begin
          p        <= LOAD;
          en       <= 1'b0;
          clk_q[i] <= 1'b0;
        end else begin
          p        <= p_next;
          en       <= en_next;
          clk_q[i] <= en_next && ({1'b0, p_next} < HIGH);
        end
      end
    end
  endgenerate

  assign c0 = clk_q[0];
  assign c1 = clk_q[1];
  assign c2 = clk_q[2];
  assign c3 = clk_q[3];

endmodule
`default_nettype wire

// File: tb/tb_pll1280.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_pll1280                                                  |
// | Purpose  : Directed self-checking bench for pll1280. Instance A uses   |
// |            the defaults; instance B uses DIV0=5, PHASE2=3,             |
// |            LOCK_CYCLES=5. Edge k=1 is the first inclk0 rising edge     |
// |            after nreset release, so t = k - 3.                         |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_pll1280;

  localparam int NE = 120;

  logic clk    = 1'b0;
  logic nreset = 1'b0;
  logic a_c0, a_c1, a_c2, a_c3, a_locked;
  logic b_c0, b_c1, b_c2, b_c3, b_locked;

  // Per-edge samples: bit 0..3 = c0..c3, bit 4 = locked.
  logic [4:0] tra [1:NE];
  logic [4:0] trb [1:NE];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pll1280 u_a (
    .inclk0(clk), .nreset(nreset),
    .c0(a_c0), .c1(a_c1), .c2(a_c2), .c3(a_c3), .locked(a_locked)
  );

  pll1280 #(.DIV0(5), .PHASE2(3), .LOCK_CYCLES(5)) u_b (
    .inclk0(clk), .nreset(nreset),
    .c0(b_c0), .c1(b_c1), .c2(b_c2), .c3(b_c3), .locked(b_locked)
  );

  task automatic check_value(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic string tg(input int run, input string s);
    return $sformatf("run%0d %s", run, s);
  endfunction

  function automatic bit sample(input bit inst, input int k, input int idx);
    if (k < 1 || k > NE) return 1'b0;
    return inst ? trb[k][idx] : tra[k][idx];
  endfunction

  function automatic int first_rise(input bit inst, input int idx);
    for (int k = 1; k <= NE; k++) if (sample(inst, k, idx)) return k;
    return 0;
  endfunction

  function automatic int next_rise(input bit inst, input int idx, input int k0);
    for (int k = k0 + 1; k <= NE; k++)
      if (sample(inst, k, idx) && !sample(inst, k - 1, idx)) return k;
    return 0;
  endfunction

  function automatic int high_len(input bit inst, input int idx, input int k0);
    int n = 0;
    int k = k0;
    while (k <= NE && sample(inst, k, idx)) begin
      n++;
      k++;
    end
    return n;
  endfunction

  task automatic chk_chan(input int run, input bit inst, input int idx,
                          input string name, input int exp_rise,
                          input int exp_high, input int exp_per);
    int r;
    r = first_rise(inst, idx);
    check_value(tg(run, {name, " first_rise_edge"}), r, exp_rise);
    if (r == 0) r = 1;
    check_value(tg(run, {name, " high_len"}), high_len(inst, idx, r), exp_high);
    check_value(tg(run, {name, " period"}), next_rise(inst, idx, r) - r, exp_per);
  endtask

  task automatic record_and_check(input int run);
    int zeros;
    int r0;
    int rises;
    for (int k = 1; k <= NE; k++) begin
      @(posedge clk);
      #1;
      tra[k] = {a_locked, a_c3, a_c2, a_c1, a_c0};
      trb[k] = {b_locked, b_c3, b_c2, b_c1, b_c0};
    end
    // A: locked at t=63 -> edge 66
    check_value(tg(run, "a locked edge65"), int'(tra[65][4]), 0);
    check_value(tg(run, "a locked edge66"), int'(tra[66][4]), 1);
    zeros = 0;
    for (int k = 66; k <= NE; k++) if (!tra[k][4]) zeros++;
    check_value(tg(run, "a locked drops"), zeros, 0);
    // A: c0 t=70, c1/c2 t=64, c3 t=66
    chk_chan(run, 1'b0, 0, "a_c0", 73, 5, 10);
    chk_chan(run, 1'b0, 1, "a_c1", 67, 1, 2);
    chk_chan(run, 1'b0, 2, "a_c2", 67, 4, 8);
    chk_chan(run, 1'b0, 3, "a_c3", 69, 4, 8);
    // c1 rises together with c0, five per c0 period
    r0 = first_rise(1'b0, 0);
    if (r0 < 2) r0 = 2;
    check_value(tg(run, "a c1 at c0 rise"), int'(sample(1'b0, r0, 1)), 1);
    rises = 0;
    for (int k = r0; k < r0 + 10; k++)
      if (sample(1'b0, k, 1) && !sample(1'b0, k - 1, 1)) rises++;
    check_value(tg(run, "a c1 rises per c0"), rises, 5);
    // B: locked t=4, c0 t=5, c1 t=4, c2 t=11, c3 t=10
    check_value(tg(run, "b locked edge"), first_rise(1'b1, 4), 7);
    chk_chan(run, 1'b1, 0, "b_c0", 8, 3, 5);
    chk_chan(run, 1'b1, 2, "b_c2", 14, 4, 8);
    check_value(tg(run, "b_c1 first_rise_edge"), first_rise(1'b1, 1), 7);
    check_value(tg(run, "b_c3 first_rise_edge"), first_rise(1'b1, 3), 13);
  endtask

  initial begin
    bit         found;
    logic [4:0] held;

    #12;
    check_value("reset a outputs", int'({a_locked, a_c3, a_c2, a_c1, a_c0}), 0);
    check_value("reset b outputs", int'({b_locked, b_c3, b_c2, b_c1, b_c0}), 0);

    @(negedge clk);
    nreset = 1'b1;
    record_and_check(1);

    // Assert reset while c0 is in its high phase, between clock edges.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (a_c0) found = 1'b1;
    end
    check_value("wait a_c0 high", int'(found), 1);
    nreset = 1'b0;
    #1;
    check_value("midreset a outputs", int'({a_locked, a_c3, a_c2, a_c1, a_c0}), 0);
    check_value("midreset b outputs", int'({b_locked, b_c3, b_c2, b_c1, b_c0}), 0);

    // Reset held with clock running: nothing may come out.
    held = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      held = held | {a_locked, a_c3, a_c2, a_c1, a_c0}
                  | {b_locked, b_c3, b_c2, b_c1, b_c0};
    end
    check_value("held reset outputs", int'(held), 0);
    nreset = 1'b1;
    record_and_check(2);

    // Short reset pulse entirely between two edges.
    @(negedge clk);
    check_value("prepulse a locked", int'(a_locked), 1);
    #1 nreset = 1'b0;
    #2 nreset = 1'b1;
    #1;
    check_value("pulse a outputs", int'({a_locked, a_c3, a_c2, a_c1, a_c0}), 0);
    check_value("pulse b outputs", int'({b_locked, b_c3, b_c2, b_c1, b_c0}), 0);
    record_and_check(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
